// File: rtl/csr_access_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : csr_access_arbiter
// Brief    : Shares the CSR file between core (port 0) and debug (port 1),
//            sequencing each access as read-old / write / respond-old.
// Revision : 1.0 - initial release
// ============================================================================
module csr_access_arbiter #(
    parameter int N_REQ = 2
) (
    input  logic                   clk,
    input  logic                   rst,

    input  logic [N_REQ-1:0]       req_valid,
    output logic [N_REQ-1:0]       req_ready,
    input  logic [N_REQ-1:0][2:0]  req_op,
    input  logic [N_REQ-1:0][11:0] req_addr,
    input  logic [N_REQ-1:0][31:0] req_data,
    input  logic [N_REQ-1:0][4:0]  req_uimm,

    output logic [N_REQ-1:0]       rsp_valid,
    input  logic [N_REQ-1:0]       rsp_ready,
    output logic [31:0]            rsp_rdata,

    output logic                   csr_wr_en,
    output logic [2:0]             csr_op,
    output logic [4:0]             csr_uimm,
    output logic [11:0]            csr_addr,
    output logic [31:0]            csr_data_in,
    input  logic [31:0]            csr_data_out,

    output logic                   busy
);

    localparam logic [1:0] c_op_nop = 2'd0;
    localparam logic [1:0] c_op_rs  = 2'd2;
    localparam logic [1:0] c_op_rc  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_next;

    logic        r_last_grant;
    logic        r_port;
    logic [2:0]  r_op;
    logic [11:0] r_addr;
    logic [31:0] r_data;
    logic [4:0]  r_uimm;
    logic [31:0] r_old;

    logic        w_grant;
    logic        w_accept;
    logic        w_src_zero;
    logic        w_suppress;

    // Round-robin: on a tie the port that was not served last wins.
    always_comb begin
        w_grant = 1'b0;
        if (&req_valid) begin
            w_grant = ~r_last_grant;
        end else if (req_valid[1]) begin
            w_grant = 1'b1;
        end
    end

    assign w_accept = (r_state == ST_IDLE) && !rst && req_valid[w_grant];

    always_comb begin
        req_ready = '0;
        if ((r_state == ST_IDLE) && !rst && (|req_valid)) begin
            req_ready[w_grant] = 1'b1;
        end
    end

    // Set/clear with an all-zero source would be a no-op write; drop it.
    assign w_src_zero = r_op[2] ? (r_uimm == 5'd0) : (r_data == 32'd0);
    assign w_suppress = (r_op[1:0] == c_op_nop) ||
                        (((r_op[1:0] == c_op_rs) || (r_op[1:0] == c_op_rc)) && w_src_zero);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_last_grant <= 1'b1;
            r_port       <= 1'b0;
            r_op         <= 3'd0;
            r_addr       <= 12'd0;
            r_data       <= 32'd0;
            r_uimm       <= 5'd0;
            r_old        <= 32'd0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_port       <= w_grant;
                r_last_grant <= w_grant;
                r_op         <= req_op[w_grant];
                r_addr       <= req_addr[w_grant];
                r_data       <= req_data[w_grant];
                r_uimm       <= req_uimm[w_grant];
            end
            if (r_state == ST_WR) begin
                r_old <= csr_data_out;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (w_accept) w_state_next = ST_RD;
            ST_RD:   w_state_next = ST_WR;
            ST_WR:   w_state_next = ST_RESP;
            ST_RESP: if (rsp_ready[r_port]) w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Write strobe is decoded from the state register, so an async reset
    // removes it in the same cycle.
    always_comb begin
        csr_wr_en = 1'b0;
        csr_op    = 3'd0;
        if (r_state == ST_WR) begin
            if (w_suppress) begin
                csr_op = {r_op[2], c_op_nop};
            end else begin
                csr_wr_en = 1'b1;
                csr_op    = r_op;
            end
        end
    end

    assign csr_addr    = r_addr;
    assign csr_data_in = r_data;
    assign csr_uimm    = r_uimm;

    generate
        for (genvar i = 0; i < N_REQ; i++) begin : g_rsp_valid
            assign rsp_valid[i] = (r_state == ST_RESP) && (r_port == 1'(i));
        end
    endgenerate

    assign rsp_rdata = r_old;
    assign busy      = (r_state != ST_IDLE);

endmodule
`default_nettype wire
